shr_arb: RTL and testbench

//  Shares one right-shift datapath between two requesters. Each requester

---
 rtl/shr_arb.sv | 132 +++++++++++++
 tb/tb_shr_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/shr_arb.sv
// shr_arb: two requesters share one right shifter through a round-robin arbiter.
// Each result is held in one output register stage. Define SHR_ARB_CNT_EN to add saturating grant counters.
module shr_arb #(
    parameter int DIN_W  = 16,
    parameter int CFG_W  = 5,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din0_valid,
    output logic             din0_ready,
    input  logic [DIN_W-1:0] din0_data,
    input  logic             cfg0_valid,
    output logic             cfg0_ready,
    input  logic [CFG_W-1:0] cfg0_data,
    input  logic             din1_valid,
    output logic             din1_ready,
    input  logic [DIN_W-1:0] din1_data,
    input  logic             cfg1_valid,
    output logic             cfg1_ready,
    input  logic [CFG_W-1:0] cfg1_data,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [DIN_W:0]   dout_data
`ifdef SHR_ARB_CNT_EN
    ,
    output logic [15:0]      gnt_cnt0,
    output logic [15:0]      gnt_cnt1
`endif
);

    logic             req0;
    logic             req1;
    logic             load;
    logic             grant;
    logic [DIN_W-1:0] win_data;
    logic [CFG_W-1:0] win_cfg;

    logic             dout_valid_q, dout_valid_d;
    logic [DIN_W:0]   dout_data_q, dout_data_d;
    logic             last_grant_q, last_grant_d;

    // Amounts at or beyond the data width saturate to the fill value.
    function automatic logic [DIN_W-1:0] shift_right(input logic [DIN_W-1:0] d,
                                                      input logic [CFG_W-1:0] amt);
        logic             fill;
        logic [DIN_W-1:0] res;
        fill = SIGNED ? d[DIN_W-1] : 1'b0;
        if (int'(amt) >= DIN_W) begin
            res = {DIN_W{fill}};
        end else if (SIGNED) begin
            res = $signed(d) >>> amt;
        end else begin
            res = d >> amt;
        end
        return res;
    endfunction

    always_comb begin
        req0 = din0_valid & cfg0_valid;
        req1 = din1_valid & cfg1_valid;
        load = (~dout_valid_q | dout_ready) & (req0 | req1) & ~rst;
        if (req0 & req1) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1;
        end
        win_data = grant ? din1_data : din0_data;
        win_cfg  = grant ? cfg1_data : cfg0_data;

        dout_valid_d = dout_valid_q;
        dout_data_d  = dout_data_q;
        last_grant_d = last_grant_q;
        if (load) begin
            dout_valid_d = 1'b1;
            dout_data_d  = {grant, shift_right(win_data, win_cfg)};
            last_grant_d = grant;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            last_grant_q <= 1'b1;
        end else begin
            dout_valid_q <= dout_valid_d;
            dout_data_q  <= dout_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Data and cfg of a requester are always consumed together.
    assign din0_ready = load & ~grant;
    assign cfg0_ready = load & ~grant;
    assign din1_ready = load & grant;
    assign cfg1_ready = load & grant;
    assign dout_valid = dout_valid_q;
    assign dout_data  = dout_data_q;

`ifdef SHR_ARB_CNT_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (load & ~grant & (cnt0_q != 16'hFFFF)) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (load & grant & (cnt1_q != 16'hFFFF)) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign gnt_cnt0 = cnt0_q;
    assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shr_arb.sv
// tb_shr_arb: bench for shr_arb with DIN_W=8, one logical-shift and one arithmetic-shift instance on shared inputs.
// Define SHR_ARB_CNT_EN to also exercise the grant counters.
module tb_shr_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       din0_valid, cfg0_valid, din1_valid, cfg1_valid;
    logic [7:0] din0_data, din1_data;
    logic [4:0] cfg0_data, cfg1_data;
    logic       dout_ready;

    logic       din0_ready, cfg0_ready, din1_ready, cfg1_ready;
    logic       dout_valid;
    logic [8:0] dout_data;

    logic       sDin0Ready, sCfg0Ready, sDin1Ready, sCfg1Ready;
    logic       sDoutValid;
    logic [8:0] sDoutData;

`ifdef SHR_ARB_CNT_EN
    logic [15:0] gntCnt0, gntCnt1, sGntCnt0, sGntCnt1;
`endif

    int passCount  = 0;
    int checkCount = 0;

    typedef struct {
        logic       ch;
        logic [7:0] din;
        logic [4:0] cfg;
        logic [7:0] expU;
        logic [7:0] expS;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    shr_arb #(.DIN_W(8), .CFG_W(5), .SIGNED(1'b0)) u8 (
        .clk(clk), .rst(rst),
        .din0_valid(din0_valid), .din0_ready(din0_ready), .din0_data(din0_data),
        .cfg0_valid(cfg0_valid), .cfg0_ready(cfg0_ready), .cfg0_data(cfg0_data),
        .din1_valid(din1_valid), .din1_ready(din1_ready), .din1_data(din1_data),
        .cfg1_valid(cfg1_valid), .cfg1_ready(cfg1_ready), .cfg1_data(cfg1_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
`ifdef SHR_ARB_CNT_EN
        , .gnt_cnt0(gntCnt0), .gnt_cnt1(gntCnt1)
`endif
    );

    shr_arb #(.DIN_W(8), .CFG_W(5), .SIGNED(1'b1)) s8 (
        .clk(clk), .rst(rst),
        .din0_valid(din0_valid), .din0_ready(sDin0Ready), .din0_data(din0_data),
        .cfg0_valid(cfg0_valid), .cfg0_ready(sCfg0Ready), .cfg0_data(cfg0_data),
        .din1_valid(din1_valid), .din1_ready(sDin1Ready), .din1_data(din1_data),
        .cfg1_valid(cfg1_valid), .cfg1_ready(sCfg1Ready), .cfg1_data(cfg1_data),
        .dout_valid(sDoutValid), .dout_ready(dout_ready), .dout_data(sDoutData)
`ifdef SHR_ARB_CNT_EN
        , .gnt_cnt0(sGntCnt0), .gnt_cnt1(sGntCnt1)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ch, input logic [7:0] d, input logic [4:0] c);
        @(negedge clk);
        if (ch) begin
            din1_data = d;  cfg1_data = c;  din1_valid = 1'b1;  cfg1_valid = 1'b1;
        end else begin
            din0_data = d;  cfg0_data = c;  din0_valid = 1'b1;  cfg0_valid = 1'b1;
        end
        #1;
    endtask

    task automatic setValids(input logic v0, input logic v1);
        din0_valid = v0;  cfg0_valid = v0;
        din1_valid = v1;  cfg1_valid = v1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic expId;

        vecs[0] = '{1'b0, 8'hF0, 5'd4,  8'h0F, 8'hFF};
        vecs[1] = '{1'b0, 8'h80, 5'd3,  8'h10, 8'hF0};
        vecs[2] = '{1'b1, 8'h80, 5'd9,  8'h00, 8'hFF};
        vecs[3] = '{1'b0, 8'h80, 5'd8,  8'h00, 8'hFF};
        vecs[4] = '{1'b1, 8'h80, 5'd0,  8'h80, 8'h80};
        vecs[5] = '{1'b1, 8'h7F, 5'd7,  8'h00, 8'h00};
        vecs[6] = '{1'b0, 8'h7F, 5'd1,  8'h3F, 8'h3F};
        vecs[7] = '{1'b1, 8'hA5, 5'd31, 8'h00, 8'hFF};
        vecs[8] = '{1'b0, 8'hC3, 5'd2,  8'h30, 8'hF0};

        // Reset with both requesters asserting valid: no ready may escape.
        rst = 1'b1;
        dout_ready = 1'b1;
        din0_data = 8'h40;  cfg0_data = 5'd1;
        din1_data = 8'h08;  cfg1_data = 5'd3;
        setValids(1'b1, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("rstValid", {31'd0, dout_valid}, 32'd0);
        checkOutput("rstData", {23'd0, dout_data}, 32'd0);
        checkOutput("rstReadys", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'd0);
        checkOutput("rstReadysS", {28'd0, sDin0Ready, sCfg0Ready, sDin1Ready, sCfg1Ready}, 32'd0);
        setValids(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Single-requester vectors through both shifter flavours.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ch, vecs[i].din, vecs[i].cfg);
            checkOutput("vecWinRdy", {31'd0, vecs[i].ch ? (din1_ready & cfg1_ready) : (din0_ready & cfg0_ready)}, 32'd1);
            checkOutput("vecLoseRdy", {31'd0, vecs[i].ch ? (din0_ready | cfg0_ready) : (din1_ready | cfg1_ready)}, 32'd0);
            @(negedge clk);
            setValids(1'b0, 1'b0);
            #1;
            checkOutput("vecDoutU", {22'd0, dout_valid, dout_data}, {22'd0, 1'b1, vecs[i].ch, vecs[i].expU});
            checkOutput("vecDoutS", {22'd0, sDoutValid, sDoutData}, {22'd0, 1'b1, vecs[i].ch, vecs[i].expS});
        end
        @(negedge clk);
        #1;
        checkOutput("idleValid", {31'd0, dout_valid}, 32'd0);
        checkOutput("idleHold", {23'd0, dout_data}, {23'd0, 1'b0, 8'h30});

        // Fresh reset, then both requesting continuously: ids alternate starting at 0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        din0_data = 8'h40;  cfg0_data = 5'd1;
        din1_data = 8'h08;  cfg1_data = 5'd3;
        setValids(1'b1, 1'b1);
        #1;
        expId = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("rrRdy0", {31'd0, din0_ready & cfg0_ready}, {31'd0, ~expId});
            checkOutput("rrRdy1", {31'd0, din1_ready & cfg1_ready}, {31'd0, expId});
            @(negedge clk);
            #1;
            checkOutput("rrDout", {22'd0, dout_valid, dout_data},
                        {22'd0, 1'b1, expId, (expId ? 8'h01 : 8'h20)});
            expId = ~expId;
        end

        // Backpressure for 3 cycles: output frozen, no readys, arbiter state frozen.
        dout_ready = 1'b0;
        #1;
        checkOutput("bpRdyNow", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("bpDout", {22'd0, dout_valid, dout_data}, {22'd0, 1'b1, 1'b1, 8'h01});
            checkOutput("bpRdy", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'd0);
        end
        dout_ready = 1'b1;
        #1;
        checkOutput("bpRelRdy", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'b1100);
        @(negedge clk);
        #1;
        checkOutput("bpRelDout", {22'd0, dout_valid, dout_data}, {22'd0, 1'b1, 1'b0, 8'h20});

        // Asynchronous reset mid-cycle while a word is pending.
        @(posedge clk);
        #2;
        checkOutput("preRstValid", {31'd0, dout_valid}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("asyncRstValid", {31'd0, dout_valid}, 32'd0);
        checkOutput("asyncRstData", {23'd0, dout_data}, 32'd0);
        checkOutput("asyncRstRdy", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postRstRdy", {28'd0, din0_ready, cfg0_ready, din1_ready, cfg1_ready}, 32'b1100);
        @(negedge clk);
        #1;
        checkOutput("postRstDout", {22'd0, dout_valid, dout_data}, {22'd0, 1'b1, 1'b0, 8'h20});

`ifdef SHR_ARB_CNT_EN
        // Five alternating grants from reset: 3 to ch0, 2 to ch1.
        setValids(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        setValids(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
        end
        setValids(1'b0, 1'b0);
        #1;
        checkOutput("cnt0", {16'd0, gntCnt0}, 32'd3);
        checkOutput("cnt1", {16'd0, gntCnt1}, 32'd2);
        checkOutput("cnt0S", {16'd0, sGntCnt0}, 32'd3);
        checkOutput("cnt1S", {16'd0, sGntCnt1}, 32'd2);

        force u8.cnt0_q = 16'hFFFE;
        @(negedge clk);
        release u8.cnt0_q;
        setValids(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
        end
        setValids(1'b0, 1'b0);
        #1;
        checkOutput("cnt0Sat", {16'd0, gntCnt0}, 32'h0000FFFF);
        checkOutput("cnt1Hold", {16'd0, gntCnt1}, 32'd2);
        checkOutput("cnt0SNoSat", {16'd0, sGntCnt0}, 32'd6);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
